// File: rtl/mips_program_loader.sv
// rtl/mips_program_loader.sv - byte-serial program loader for the single-cycle MIPS instruction RAM
//
// Receives a length-prefixed byte stream (LEN_HI, LEN_LO, then 4*N payload
// bytes, most significant byte of each word first) and writes each assembled
// word into the instruction RAM. The CPU is held in reset until a complete,
// valid image has been stored.
//
// Optional feature macro: LOADER_CHECKSUM_EN -- when defined, a trailing
// XOR checksum byte over the payload is required before DONE.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   begins a session (only in IDLE, DONE or ERROR)
//   rx_data/valid/ready     byte stream input, transfer on valid & ready
//   imem_we/addr/wdata      one-cycle instruction RAM write port
//   cpu_reset               CPU reset, low only in DONE
//   busy, done, error       session status
module mips_program_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_FLUSH, S_DONE, S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_len_hi;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_buf;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_idx;
  logic [31:0]           r_imem_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_xfer;
  logic                  w_start;
  logic [15:0]           w_len;
  logic                  w_len_over;
  logic                  w_word_done;
  logic [ADDR_WIDTH:0]   w_idx_inc;
  logic                  w_last_word;

  assign w_xfer      = rx_valid & rx_ready;
  assign w_start     = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
  assign w_len       = {r_len_hi, rx_data};
  assign w_len_over  = w_len > 16'(DEPTH);
  assign w_word_done = (r_byte_cnt == 2'd3);
  // Widened by one bit so N = DEPTH compares correctly against the stored count.
  assign w_idx_inc   = {1'b0, r_word_idx} + (ADDR_WIDTH + 1)'(1);
  assign w_last_word = (w_idx_inc == r_len);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) begin
        if (w_len_over) w_next = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
        else if (w_len == 16'd0) w_next = S_CHECK;
`else
        else if (w_len == 16'd0) w_next = S_DONE;
`endif
        else w_next = S_DATA;
      end
      S_DATA: if (w_xfer && w_word_done && w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
        w_next = S_CHECK;
`else
        w_next = S_FLUSH;
`endif
      end
      S_FLUSH: w_next = S_DONE;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (w_xfer) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly and the registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_hi     <= 8'd0;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= 2'd0;
      r_buf        <= 24'd0;
      r_imem_we    <= 1'b0;
      r_imem_idx   <= '0;
      r_imem_wdata <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      if (w_start) begin
        r_word_idx <= '0;
        r_byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        r_csum     <= 8'd0;
`endif
      end
      if (r_state == S_LEN_HI && w_xfer) r_len_hi <= rx_data;
      // Only the low bits are kept; oversize lengths never leave LEN_LO.
      if (r_state == S_LEN_LO && w_xfer) r_len <= w_len[ADDR_WIDTH:0];
      if (r_state == S_DATA && w_xfer) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_buf      <= {r_buf[15:0], rx_data};
`ifdef LOADER_CHECKSUM_EN
        r_csum     <= r_csum ^ rx_data;
`endif
        if (w_word_done) begin
          r_imem_we    <= 1'b1;
          r_imem_idx   <= r_word_idx;
          r_imem_wdata <= {r_buf, rx_data};
          r_word_idx   <= r_word_idx + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = {{(30 - ADDR_WIDTH){1'b0}}, r_imem_idx, 2'b00};
  assign imem_wdata = r_imem_wdata;

  // Output decode; start takes effect on done/error/cpu_reset in the cycle it is seen.
  always_comb begin
    rx_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_FLUSH: busy = 1'b1;
      S_DONE: begin
        done      = ~start;
        cpu_reset = start;
      end
      S_ERROR: error = ~start;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// tb/tb_mips_program_loader.sv - self-checking bench for mips_program_loader
module tb_mips_program_loader;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, cpu_reset, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          e;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wlog[$];
  logic [31:0] ram[DEPTH];
  logic [31:0] exp_ram[DEPTH];

  mips_program_loader #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction RAM model plus a log of every write and the edge count it appeared after.
  always @(negedge clk) begin
    if (imem_we) begin
      wlog.push_back('{cyc, imem_addr, imem_wdata});
      if (imem_addr < 32'(4 * DEPTH)) ram[imem_addr[5:2]] = imem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_ram[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // Drives bytes in order; acc receives the edge number on which each byte transferred.
  task automatic send(input logic [7:0] s[$], input int mode, output int acc[$]);
    int idx = 0;
    int budget = 0;
    bit ph = 1'b0;
    acc.delete();
    while (idx < s.size() && budget < 1000) begin
      @(negedge clk);
      budget++;
      rx_data = s[idx];
      case (mode)
        0:       rx_valid = 1'b1;
        1:       begin rx_valid = ph; ph = ~ph; end
        default: rx_valid = 1'($urandom_range(0, 1));
      endcase
      if (rx_valid && rx_ready) begin
        acc.push_back(cyc + 1);
        idx++;
      end
    end
    chk("stream_accepted", idx, s.size());
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bit was_done;
    @(negedge clk);
    was_done = done;
    start = 1'b1;
    #1;
    if (was_done) chk("cpu_reset_on_start", cpu_reset, 1);
    wlog.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full session: builds the stream, predicts writes and final status from the format rules.
  task automatic run(input logic [31:0] w[$], input logic [15:0] n, input int mode,
                     input bit corrupt, input string tag);
    logic [7:0] s[$];
    int         acc[$];
    wr_t        ew[$];
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    bit         ok;
    int         fin;
    int         lim;
    pulse_start();
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    if (n <= DEPTH) begin
      for (int i = 0; i < int'(n); i++)
        for (int k = 3; k >= 0; k--) begin
          b = w[i][8*k +: 8];
          s.push_back(b);
          x ^= b;
        end
`ifdef LOADER_CHECKSUM_EN
      s.push_back(x ^ {7'd0, corrupt});
`endif
    end
    ok = (n <= DEPTH) && !corrupt;
    send(s, mode, acc);
    if (acc.size() != s.size()) return;
    fin = acc[acc.size() - 1];
`ifndef LOADER_CHECKSUM_EN
    if (ok && n != 0) fin++;
`endif
    if (n <= DEPTH)
      for (int i = 0; i < int'(n); i++) begin
        ew.push_back('{acc[2 + 4*i + 3], 32'(i * 4), w[i]});
        exp_ram[i] = w[i];
      end
    while (cyc < fin) begin
      chk({tag, "_not_yet_done"}, {done, error, cpu_reset}, 3'b001);
      @(negedge clk);
    end
    chk({tag, "_done"}, done, ok);
    chk({tag, "_error"}, error, !ok);
    chk({tag, "_cpu_reset"}, cpu_reset, !ok);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_nwrites"}, wlog.size(), ew.size());
    lim = (wlog.size() < ew.size()) ? wlog.size() : ew.size();
    for (int i = 0; i < lim; i++)
      chk({tag, "_write"}, {32'(wlog[i].e), wlog[i].a, wlog[i].d},
          {32'(ew[i].e), ew[i].a, ew[i].d});
    chk_ram({tag, "_ram"});
  endtask

  initial begin
    logic [31:0] q[$];
    logic [7:0]  s[$];
    int          acc[$];
    int          n;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'hDEAD0000 | 32'(i);
      exp_ram[i] = 32'hDEAD0000 | 32'(i);
    end

    #12;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    reset = 1'b0;

    q = {32'h20080001, 32'h21090002};
    run(q, 16'd2, 0, 1'b0, "full_rate");
    run(q, 16'd2, 1, 1'b0, "toggle");

    q.delete();
    run(q, 16'd17, 0, 1'b0, "oversize");
    q = {32'h12345678};
    run(q, 16'd1, 1, 1'b0, "after_error");

    q.delete();
    run(q, 16'd0, 0, 1'b0, "zero_len");
`ifdef LOADER_CHECKSUM_EN
    run(q, 16'd0, 0, 1'b1, "zero_len_bad_sum");
    q = {32'h340A00FF};
    run(q, 16'd1, 0, 1'b0, "sum_ok");
    q = {32'h340A00FF};
    run(q, 16'd1, 0, 1'b1, "sum_bad");
`endif

    for (int t = 0; t < 4; t++) begin
      n = (t == 3) ? DEPTH : $urandom_range(1, DEPTH - 1);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom);
      run(q, 16'(n), 2, 1'b0, "random");
    end

    // Reset in the middle of the second word.
    q = {$urandom, $urandom};
    pulse_start();
    s = {8'h00, 8'h02, q[0][31:24], q[0][23:16], q[0][15:8], q[0][7:0],
         q[1][31:24], q[1][23:16]};
    send(s, 0, acc);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_cpu_reset", cpu_reset, 1);
    chk("mid_rx_ready", rx_ready, 0);
    chk("mid_imem_we", imem_we, 0);
    chk("mid_imem_addr", imem_addr, 0);
    chk("mid_imem_wdata", imem_wdata, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_error", error, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_ram[0] = q[0];
    chk("mid_nwrites", wlog.size(), 1);
    chk_ram("mid_ram");
    q = {$urandom, $urandom, $urandom};
    run(q, 16'd3, 0, 1'b0, "reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
